// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/retire controller for the RV32I PC path.
// Sequences FETCH -> EXEC per instruction, drives the PC load enable and
// next-PC select on retirement, and halts on fetch timeout, misaligned
// control-flow target or ECALL.
module fetch_sequencer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        ResetN,
  input  logic        IReady,
  input  logic        DStall,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic        BranchTaken,
  input  logic        Ecall,
  input  logic        Resume,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  output logic        IReq,
  output logic        InstrValid,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        Halted,
  output logic [1:0]  FaultCode,
  output logic [31:0] InstRet
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 32;
  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = 8'(TIMEOUT) - 8'd1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  localparam logic [1:0] SRC_PC4 = 2'b00;
  localparam logic [1:0] SRC_TGT = 2'b01;
  localparam logic [1:0] SRC_ALU = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b01;
  localparam logic [1:0] FAULT_ALIGN   = 2'b10;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        sel;
  logic              misaligned;
  logic              timeout_hit;
  logic              retire;

  // Upper target bits are not needed; only the alignment bits are checked.
  logic unused_bits;
  assign unused_bits = ^{PCTarget[31:2], ALUResult[31:2]};

  // Next-PC source selection and fault conditions.
  always_comb begin
    sel = SRC_PC4;
    if (JumpReg) begin
      sel = SRC_ALU;
    end else if (Jump || (Branch && BranchTaken)) begin
      sel = SRC_TGT;
    end
    misaligned  = ((sel == SRC_TGT) && (PCTarget[1:0]  != 2'b00)) ||
                  ((sel == SRC_ALU) && (ALUResult[1:0] != 2'b00));
    timeout_hit = TIMEOUT_EN && !IReady && (wait_cnt == TIMEOUT_LAST);
  end

  // State register.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_RST;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (IReady) begin
          state_nxt = ST_EXEC;
        end else if (timeout_hit) begin
          state_nxt = ST_HALT;
        end
      end
      ST_EXEC: begin
        if (!DStall) begin
          state_nxt = (misaligned || Ecall) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (Resume && (FaultCode == FAULT_NONE)) begin
          state_nxt = ST_FETCH;
        end
      end
      default:  state_nxt = ST_RST;
    endcase
  end

  // Moore decodes plus the combinational retire-cycle PC controls.
  always_comb begin
    IReq       = 1'b0;
    InstrValid = 1'b0;
    Halted     = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = SRC_PC4;
    retire     = 1'b0;
    case (state)
      ST_FETCH: IReq = 1'b1;
      ST_EXEC: begin
        InstrValid = 1'b1;
        if (!DStall && !misaligned) begin
          retire = 1'b1;
          if (!Ecall) begin
            PCWrite = 1'b1;
            PCSrc   = sel;
          end
        end
      end
      ST_HALT: begin
        Halted = 1'b1;
        if (Resume && (FaultCode == FAULT_NONE)) begin
          PCWrite = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Fetch wait counter: counts FETCH cycles, cleared whenever outside FETCH.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      wait_cnt <= '0;
    end else if (state == ST_FETCH) begin
      wait_cnt <= wait_cnt + 8'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky fault code and retired-instruction counter.
  always_ff @(posedge CLK or negedge ResetN) begin
    if (!ResetN) begin
      FaultCode <= FAULT_NONE;
      InstRet   <= '0;
    end else begin
      if ((state == ST_FETCH) && timeout_hit) begin
        FaultCode <= FAULT_TIMEOUT;
      end else if ((state == ST_EXEC) && !DStall && misaligned) begin
        FaultCode <= FAULT_ALIGN;
      end
      if (retire) begin
        InstRet <= InstRet + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer (built with TIMEOUT = 4).
module tb_fetch_sequencer;

  logic        CLK;
  logic        ResetN;
  logic        IReady, DStall, Branch, Jump, JumpReg, BranchTaken, Ecall, Resume;
  logic [31:0] PCTarget, ALUResult;
  logic        IReq, InstrValid, PCWrite, Halted;
  logic [1:0]  PCSrc, FaultCode;
  logic [31:0] InstRet;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer #(.TIMEOUT(4)) dut (
    .CLK(CLK), .ResetN(ResetN), .IReady(IReady), .DStall(DStall),
    .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg), .BranchTaken(BranchTaken),
    .Ecall(Ecall), .Resume(Resume), .PCTarget(PCTarget), .ALUResult(ALUResult),
    .IReq(IReq), .InstrValid(InstrValid), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Halted(Halted), .FaultCode(FaultCode), .InstRet(InstRet)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock and settle just after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    IReady = 0; DStall = 0; Branch = 0; Jump = 0; JumpReg = 0;
    BranchTaken = 0; Ecall = 0; Resume = 0; PCTarget = '0; ALUResult = '0;
  endtask

  // Hold reset for two clocks and release just after an edge; DUT then sits in RST.
  task automatic do_reset();
    clear_inputs();
    ResetN = 0;
    repeat (2) @(posedge CLK);
    #1;
    ResetN = 1;
  endtask

  // From RST: one cycle to FETCH, fetch with IReady, land in EXEC.
  task automatic go_exec_from_rst();
    cyc();
    IReady = 1;
    cyc();
    IReady = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ResetN = 0;
    #3;
    n_checks++;
    if ({IReq, InstrValid, PCWrite, PCSrc, Halted, FaultCode} !== 8'h00 || InstRet !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ctl=%0h instret=%0d expected ctl=0 instret=0",
               {IReq, InstrValid, PCWrite, PCSrc, Halted, FaultCode}, InstRet);
    end
    do_reset();
    #1;
    n_checks++;
    if (IReq !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_cycle_ireq: got %0b expected 0", IReq);
    end
  endtask

  task automatic test_sequential();
    int pcw_count;
    do_reset();
    IReady = 1;
    pcw_count = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_checks++;
      if (IReq !== ((i % 2) == 0) || PCWrite !== ((i % 2) == 1) || PCSrc !== 2'b00) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: got ireq=%0b pcwrite=%0b pcsrc=%0b expected ireq=%0b pcwrite=%0b pcsrc=0",
                 i + 1, IReq, PCWrite, PCSrc, (i % 2) == 0, (i % 2) == 1);
      end
      if (PCWrite) pcw_count++;
    end
    cyc();
    n_checks++;
    if (InstRet !== 32'd5 || pcw_count != 5) begin
      n_fail++;
      $display("FAIL seq_instret: got instret=%0d pcwrites=%0d expected 5 and 5", InstRet, pcw_count);
    end
  endtask

  task automatic test_branch_jump();
    do_reset();
    go_exec_from_rst();
    Branch = 1; BranchTaken = 1; PCTarget = 32'h40;
    #1;
    n_checks++;
    if (PCWrite !== 1'b1 || PCSrc !== 2'b01 || InstrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_taken: got pcwrite=%0b pcsrc=%0b valid=%0b expected 1 01 1", PCWrite, PCSrc, InstrValid);
    end
    BranchTaken = 0;
    #1;
    n_checks++;
    if (PCWrite !== 1'b1 || PCSrc !== 2'b00) begin
      n_fail++;
      $display("FAIL branch_not_taken: got pcwrite=%0b pcsrc=%0b expected 1 00", PCWrite, PCSrc);
    end
    cyc();
    clear_inputs();
    IReady = 1;
    cyc();
    IReady = 0;
    JumpReg = 1; Jump = 1; ALUResult = 32'h100; PCTarget = 32'h44;
    #1;
    n_checks++;
    if (PCWrite !== 1'b1 || PCSrc !== 2'b10) begin
      n_fail++;
      $display("FAIL jalr_priority: got pcwrite=%0b pcsrc=%0b expected 1 10", PCWrite, PCSrc);
    end
    cyc();
    clear_inputs();
    n_checks++;
    if (InstRet !== 32'd2 || IReq !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_instret: got instret=%0d ireq=%0b expected 2 1", InstRet, IReq);
    end
  endtask

  task automatic test_stall();
    do_reset();
    go_exec_from_rst();
    DStall = 1;
    IReady = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (InstrValid !== 1'b1 || PCWrite !== 1'b0 || PCSrc !== 2'b00) begin
        n_fail++;
        $display("FAIL stall_cycle%0d: got valid=%0b pcwrite=%0b pcsrc=%0b expected 1 0 00",
                 i, InstrValid, PCWrite, PCSrc);
      end
      cyc();
    end
    DStall = 0;
    IReady = 0;
    #1;
    n_checks++;
    if (InstrValid !== 1'b1 || PCWrite !== 1'b1 || InstRet !== 32'd0) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%0b pcwrite=%0b instret=%0d expected 1 1 0",
               InstrValid, PCWrite, InstRet);
    end
    cyc();
    n_checks++;
    if (InstRet !== 32'd1 || InstrValid !== 1'b0 || IReq !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_retire: got instret=%0d valid=%0b ireq=%0b expected 1 0 1", InstRet, InstrValid, IReq);
    end
  endtask

  task automatic test_timeout();
    // Three-cycle fetch waits twice in a row: counter clears between fetches.
    do_reset();
    cyc(); cyc(); cyc();
    IReady = 1;
    cyc();
    IReady = 0;
    cyc(); cyc(); cyc();
    IReady = 1;
    cyc();
    IReady = 0;
    n_checks++;
    if (InstrValid !== 1'b1 || FaultCode !== 2'b00 || Halted !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_clear: got valid=%0b fault=%0b halted=%0b expected 1 00 0", InstrValid, FaultCode, Halted);
    end
    // Four FETCH cycles without IReady trigger the timeout.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++;
      if (IReq !== 1'b1 || Halted !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_fetch%0d: got ireq=%0b halted=%0b expected 1 0", i, IReq, Halted);
      end
    end
    cyc();
    n_checks++;
    if (Halted !== 1'b1 || FaultCode !== 2'b01 || IReq !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_halt: got halted=%0b fault=%0b ireq=%0b expected 1 01 0", Halted, FaultCode, IReq);
    end
    Resume = 1;
    #1;
    n_checks++;
    if (PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_resume_pcwrite: got %0b expected 0", PCWrite);
    end
    cyc();
    Resume = 0;
    cyc();
    n_checks++;
    if (Halted !== 1'b1 || IReq !== 1'b0 || FaultCode !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_resume_ignored: got halted=%0b ireq=%0b fault=%0b expected 1 0 01", Halted, IReq, FaultCode);
    end
  endtask

  task automatic test_misaligned();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      go_exec_from_rst();
      Jump = 1; PCTarget = 32'h42; Ecall = (k == 1);
      #1;
      n_checks++;
      if (PCWrite !== 1'b0 || PCSrc !== 2'b00) begin
        n_fail++;
        $display("FAIL misalign%0d_pcwrite: got pcwrite=%0b pcsrc=%0b expected 0 00", k, PCWrite, PCSrc);
      end
      cyc();
      clear_inputs();
      n_checks++;
      if (Halted !== 1'b1 || FaultCode !== 2'b10 || InstRet !== 32'd0) begin
        n_fail++;
        $display("FAIL misalign%0d_halt: got halted=%0b fault=%0b instret=%0d expected 1 10 0",
                 k, Halted, FaultCode, InstRet);
      end
    end
    // JALR with a misaligned ALU target.
    do_reset();
    go_exec_from_rst();
    JumpReg = 1; ALUResult = 32'h101;
    cyc();
    clear_inputs();
    n_checks++;
    if (Halted !== 1'b1 || FaultCode !== 2'b10) begin
      n_fail++;
      $display("FAIL misalign_jalr: got halted=%0b fault=%0b expected 1 10", Halted, FaultCode);
    end
  endtask

  task automatic test_ecall_resume();
    do_reset();
    cyc();
    Resume = 1;          // ignored outside HALT
    IReady = 1;
    cyc();
    IReady = 0;
    Resume = 0;
    Ecall = 1;
    #1;
    n_checks++;
    if (PCWrite !== 1'b0 || PCSrc !== 2'b00 || InstrValid !== 1'b1) begin
      n_fail++;
      $display("FAIL ecall_pcwrite: got pcwrite=%0b pcsrc=%0b valid=%0b expected 0 00 1", PCWrite, PCSrc, InstrValid);
    end
    cyc();
    Ecall = 0;
    n_checks++;
    if (Halted !== 1'b1 || InstRet !== 32'd1 || FaultCode !== 2'b00) begin
      n_fail++;
      $display("FAIL ecall_halt: got halted=%0b instret=%0d fault=%0b expected 1 1 00", Halted, InstRet, FaultCode);
    end
    cyc();
    n_checks++;
    if (Halted !== 1'b1 || PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL ecall_hold: got halted=%0b pcwrite=%0b expected 1 0", Halted, PCWrite);
    end
    Resume = 1;
    #1;
    n_checks++;
    if (PCWrite !== 1'b1 || PCSrc !== 2'b00) begin
      n_fail++;
      $display("FAIL resume_pcwrite: got pcwrite=%0b pcsrc=%0b expected 1 00", PCWrite, PCSrc);
    end
    cyc();
    Resume = 0;
    n_checks++;
    if (IReq !== 1'b1 || Halted !== 1'b0 || PCWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL resume_fetch: got ireq=%0b halted=%0b pcwrite=%0b expected 1 0 0", IReq, Halted, PCWrite);
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    IReady = 1;
    cyc(); cyc(); cyc(); cyc();
    IReady = 0;
    #1;
    n_checks++;
    if (InstrValid !== 1'b1 || PCWrite !== 1'b1 || InstRet !== 32'd1) begin
      n_fail++;
      $display("FAIL pre_reset_exec: got valid=%0b pcwrite=%0b instret=%0d expected 1 1 1", InstrValid, PCWrite, InstRet);
    end
    ResetN = 0;
    #1;
    n_checks++;
    if ({IReq, InstrValid, PCWrite, PCSrc, Halted, FaultCode} !== 8'h00 || InstRet !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_exec: got ctl=%0h instret=%0d expected ctl=0 instret=0",
               {IReq, InstrValid, PCWrite, PCSrc, Halted, FaultCode}, InstRet);
    end
    cyc();
    ResetN = 1;
  endtask

  initial begin
    clear_inputs();
    ResetN = 0;
    test_reset();
    test_sequential();
    test_branch_jump();
    test_stall();
    test_timeout();
    test_misaligned();
    test_ecall_resume();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
